rob_buffer: RTL and testbench

ROB_BUFFER -- requirements
Module: rob_buffer

---
 rtl/rob_buffer.sv | 198 +++++++++++++++++++
 tb/tb_rob_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_buffer.sv
// Reorder buffer: in-order allocation at tail, out-of-order writeback, in-order commit at head.
// Operand lookups see same-cycle writeback data through a bypass path.
module rob_buffer #(
    parameter int unsigned ROB_DEPTH      = 16,
    parameter int unsigned ROB_IDX_WIDTH  = 4,
    parameter int unsigned RF_ADDR_WIDTH  = 5,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned EXC_TYPE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,

    input  logic                      alloc_en,
    input  logic                      alloc_reg_write_en,
    input  logic [RF_ADDR_WIDTH-1:0]  alloc_reg_write_addr,
    input  logic [ADDR_WIDTH-1:0]     alloc_pc,
    input  logic [EXC_TYPE_WIDTH-1:0] alloc_exception_type,
    output logic [ROB_IDX_WIDTH-1:0]  alloc_idx,
    output logic                      full,
    output logic                      empty,

    input  logic                      wb_en,
    input  logic [ROB_IDX_WIDTH-1:0]  wb_idx,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic [EXC_TYPE_WIDTH-1:0] wb_exception_type,

    input  logic [ROB_IDX_WIDTH-1:0]  read_idx_1,
    input  logic [ROB_IDX_WIDTH-1:0]  read_idx_2,
    output logic                      read_done_1,
    output logic                      read_done_2,
    output logic [DATA_WIDTH-1:0]     read_data_1,
    output logic [DATA_WIDTH-1:0]     read_data_2,

    input  logic                      commit_stall,
    output logic                      commit_en,
    output logic [ROB_IDX_WIDTH-1:0]  commit_idx,
    output logic                      commit_reg_write_en,
    output logic [RF_ADDR_WIDTH-1:0]  commit_reg_write_addr,
    output logic [DATA_WIDTH-1:0]     commit_data,
    output logic [ADDR_WIDTH-1:0]     commit_pc,
    output logic [EXC_TYPE_WIDTH-1:0] commit_exception_type
);

    localparam logic [ROB_IDX_WIDTH:0]   FULL_COUNT = ROB_DEPTH[ROB_IDX_WIDTH:0];
    localparam logic [ROB_IDX_WIDTH:0]   CNT_ONE    = 1;
    localparam logic [ROB_IDX_WIDTH-1:0] IDX_ONE    = 1;

    logic [ROB_DEPTH-1:0]      valid_q, valid_d;
    logic [ROB_DEPTH-1:0]      done_q, done_d;
    logic [ROB_DEPTH-1:0]      rwe_q, rwe_d;
    logic [RF_ADDR_WIDTH-1:0]  waddr_q [ROB_DEPTH];
    logic [RF_ADDR_WIDTH-1:0]  waddr_d [ROB_DEPTH];
    logic [ADDR_WIDTH-1:0]     pc_q    [ROB_DEPTH];
    logic [ADDR_WIDTH-1:0]     pc_d    [ROB_DEPTH];
    logic [DATA_WIDTH-1:0]     data_q  [ROB_DEPTH];
    logic [DATA_WIDTH-1:0]     data_d  [ROB_DEPTH];
    logic [EXC_TYPE_WIDTH-1:0] exc_q   [ROB_DEPTH];
    logic [EXC_TYPE_WIDTH-1:0] exc_d   [ROB_DEPTH];

    logic [ROB_IDX_WIDTH-1:0]  head_q, head_d;
    logic [ROB_IDX_WIDTH-1:0]  tail_q, tail_d;
    logic [ROB_IDX_WIDTH:0]    count_q, count_d;

    logic alloc_fire;
    logic wb_fire;
    logic commit_fire;

    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign alloc_idx = tail_q;

    // A full buffer rejects allocation even if the head retires this cycle.
    assign alloc_fire  = alloc_en && !full && !flush;
    assign wb_fire     = wb_en && valid_q[wb_idx] && !flush;
    assign commit_fire = !empty && valid_q[head_q] && done_q[head_q] && !commit_stall && !flush;

    // Entry next-state; writeback is applied before the commit clear so a
    // late writeback to the retiring head cannot resurrect it.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        rwe_d   = rwe_q;
        waddr_d = waddr_q;
        pc_d    = pc_q;
        data_d  = data_q;
        exc_d   = exc_q;
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
        end else begin
            if (wb_fire) begin
                done_d[wb_idx] = 1'b1;
                data_d[wb_idx] = wb_data;
                exc_d[wb_idx]  = exc_q[wb_idx] | wb_exception_type;
            end
            if (commit_fire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
            end
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                rwe_d[tail_q]   = alloc_reg_write_en;
                waddr_d[tail_q] = alloc_reg_write_addr;
                pc_d[tail_q]    = alloc_pc;
                data_d[tail_q]  = '0;
                exc_d[tail_q]   = alloc_exception_type;
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_fire) begin
                tail_d = tail_q + IDX_ONE;
            end
            if (commit_fire) begin
                head_d = head_q + IDX_ONE;
            end
            if (alloc_fire && !commit_fire) begin
                count_d = count_q + CNT_ONE;
            end else if (commit_fire && !alloc_fire) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            done_q  <= '0;
            rwe_q   <= '0;
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                waddr_q[i] <= '0;
                pc_q[i]    <= '0;
                data_q[i]  <= '0;
                exc_q[i]   <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            rwe_q   <= rwe_d;
            waddr_q <= waddr_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Operand lookup with same-cycle writeback bypass.
    always_comb begin
        read_done_1 = 1'b0;
        read_data_1 = '0;
        if (wb_fire && (wb_idx == read_idx_1)) begin
            read_done_1 = 1'b1;
            read_data_1 = wb_data;
        end else if (valid_q[read_idx_1] && done_q[read_idx_1]) begin
            read_done_1 = 1'b1;
            read_data_1 = data_q[read_idx_1];
        end
    end

    always_comb begin
        read_done_2 = 1'b0;
        read_data_2 = '0;
        if (wb_fire && (wb_idx == read_idx_2)) begin
            read_done_2 = 1'b1;
            read_data_2 = wb_data;
        end else if (valid_q[read_idx_2] && done_q[read_idx_2]) begin
            read_done_2 = 1'b1;
            read_data_2 = data_q[read_idx_2];
        end
    end

    assign commit_en             = commit_fire;
    assign commit_idx            = head_q;
    assign commit_reg_write_en   = rwe_q[head_q];
    assign commit_reg_write_addr = waddr_q[head_q];
    assign commit_data           = data_q[head_q];
    assign commit_pc             = pc_q[head_q];
    assign commit_exception_type = exc_q[head_q];

endmodule

// File: tb/tb_rob_buffer.sv
// Directed, table-driven bench for rob_buffer: inputs are driven on the falling edge and
// combinational outputs are compared 1ns later against hand-computed expectations.
module tb_rob_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        alloc_en;
    logic        alloc_reg_write_en;
    logic [4:0]  alloc_reg_write_addr;
    logic [31:0] alloc_pc;
    logic [7:0]  alloc_exception_type;
    logic [3:0]  alloc_idx;
    logic        full;
    logic        empty;
    logic        wb_en;
    logic [3:0]  wb_idx;
    logic [31:0] wb_data;
    logic [7:0]  wb_exception_type;
    logic [3:0]  read_idx_1;
    logic [3:0]  read_idx_2;
    logic        read_done_1;
    logic        read_done_2;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic        commit_stall;
    logic        commit_en;
    logic [3:0]  commit_idx;
    logic        commit_reg_write_en;
    logic [4:0]  commit_reg_write_addr;
    logic [31:0] commit_data;
    logic [31:0] commit_pc;
    logic [7:0]  commit_exception_type;

    int checks   = 0;
    int failures = 0;

    rob_buffer dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .alloc_en             (alloc_en),
        .alloc_reg_write_en   (alloc_reg_write_en),
        .alloc_reg_write_addr (alloc_reg_write_addr),
        .alloc_pc             (alloc_pc),
        .alloc_exception_type (alloc_exception_type),
        .alloc_idx            (alloc_idx),
        .full                 (full),
        .empty                (empty),
        .wb_en                (wb_en),
        .wb_idx               (wb_idx),
        .wb_data              (wb_data),
        .wb_exception_type    (wb_exception_type),
        .read_idx_1           (read_idx_1),
        .read_idx_2           (read_idx_2),
        .read_done_1          (read_done_1),
        .read_done_2          (read_done_2),
        .read_data_1          (read_data_1),
        .read_data_2          (read_data_2),
        .commit_stall         (commit_stall),
        .commit_en            (commit_en),
        .commit_idx           (commit_idx),
        .commit_reg_write_en  (commit_reg_write_en),
        .commit_reg_write_addr(commit_reg_write_addr),
        .commit_data          (commit_data),
        .commit_pc            (commit_pc),
        .commit_exception_type(commit_exception_type)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ae;
        logic [4:0]  aa;
        logic [31:0] apc;
        logic        we;
        logic [3:0]  wi;
        logic [31:0] wd;
        logic [7:0]  wx;
        logic        st;
        logic        fl;
        logic [3:0]  ri;
        logic        e_cen;
        logic [3:0]  e_cidx;
        logic [31:0] e_cdata;
        logic [4:0]  e_caddr;
        logic [31:0] e_cpc;
        logic [7:0]  e_cexc;
        logic        e_full;
        logic        e_empty;
        logic [3:0]  e_aidx;
        logic        e_rd;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t v(
        input logic ae, input logic [4:0] aa, input logic [31:0] apc,
        input logic we, input logic [3:0] wi, input logic [31:0] wd, input logic [7:0] wx,
        input logic st, input logic fl, input logic [3:0] ri,
        input logic ce, input logic [3:0] ci, input logic [31:0] cd, input logic [4:0] ca,
        input logic [31:0] cpc, input logic [7:0] cx,
        input logic fu, input logic em, input logic [3:0] ai,
        input logic rd, input logic [31:0] rdat);
        vec_t r;
        r.ae = ae; r.aa = aa; r.apc = apc;
        r.we = we; r.wi = wi; r.wd = wd; r.wx = wx;
        r.st = st; r.fl = fl; r.ri = ri;
        r.e_cen = ce; r.e_cidx = ci; r.e_cdata = cd; r.e_caddr = ca; r.e_cpc = cpc;
        r.e_cexc = cx; r.e_full = fu; r.e_empty = em; r.e_aidx = ai;
        r.e_rd = rd; r.e_rdata = rdat;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_common(input string tag, input vec_t vv);
        chk({tag, " commit_en"}, 32'(commit_en), 32'(vv.e_cen));
        chk({tag, " full"}, 32'(full), 32'(vv.e_full));
        chk({tag, " empty"}, 32'(empty), 32'(vv.e_empty));
        chk({tag, " alloc_idx"}, 32'(alloc_idx), 32'(vv.e_aidx));
        chk({tag, " read_done_1"}, 32'(read_done_1), 32'(vv.e_rd));
        chk({tag, " read_data_1"}, read_data_1, vv.e_rdata);
        chk({tag, " read_done_2"}, 32'(read_done_2), 32'(vv.e_rd));
        chk({tag, " read_data_2"}, read_data_2, vv.e_rdata);
        if (vv.e_cen) begin
            chk({tag, " commit_idx"}, 32'(commit_idx), 32'(vv.e_cidx));
            chk({tag, " commit_data"}, commit_data, vv.e_cdata);
            chk({tag, " commit_addr"}, 32'(commit_reg_write_addr), 32'(vv.e_caddr));
            chk({tag, " commit_rwe"}, 32'(commit_reg_write_en), 32'(vv.e_caddr != 5'd0));
            chk({tag, " commit_pc"}, commit_pc, vv.e_cpc);
            chk({tag, " commit_exc"}, 32'(commit_exception_type), 32'(vv.e_cexc));
        end
    endtask

    task automatic apply_vec(input string tag, input vec_t vv);
        @(negedge clk);
        alloc_en             = vv.ae;
        alloc_reg_write_en   = (vv.aa != 5'd0);
        alloc_reg_write_addr = vv.aa;
        alloc_pc             = vv.apc;
        alloc_exception_type = 8'h00;
        wb_en                = vv.we;
        wb_idx               = vv.wi;
        wb_data              = vv.wd;
        wb_exception_type    = vv.wx;
        commit_stall         = vv.st;
        flush                = vv.fl;
        read_idx_1           = vv.ri;
        read_idx_2           = vv.ri;
        #1;
        check_common(tag, vv);
    endtask

    vec_t tbl [22];
    vec_t hv  [23];

    initial begin
        // Basic round trip, out-of-order writeback, bypass, and flush priority.
        tbl[0]  = v(1, 5, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[1]  = v(0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        tbl[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    1, 0, 32'hDEAD_BEEF, 5, 32'h0040_0000, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        tbl[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tbl[4]  = v(1, 1, 32'h104, 0, 0, 0, 0, 0, 0, 1,
                    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tbl[5]  = v(1, 2, 32'h108, 0, 0, 0, 0, 0, 0, 1,
                    0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        tbl[6]  = v(1, 3, 32'h10C, 0, 0, 0, 0, 0, 0, 2,
                    0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        tbl[7]  = v(0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 3,
                    0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 32'h33);
        tbl[8]  = v(0, 0, 0, 1, 2, 32'h22, 0, 0, 0, 2,
                    0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 32'h22);
        tbl[9]  = v(0, 0, 0, 1, 1, 32'h11, 0, 0, 0, 3,
                    0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 32'h33);
        tbl[10] = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 5,
                    0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
        tbl[11] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                    1, 1, 32'h11, 1, 32'h104, 0, 0, 0, 4, 1, 32'h11);
        tbl[12] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                    1, 2, 32'h22, 2, 32'h108, 0, 0, 0, 4, 0, 0);
        tbl[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2,
                    1, 3, 32'h33, 3, 32'h10C, 0, 0, 0, 4, 0, 0);
        tbl[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 3,
                    0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        tbl[15] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 3,
                    0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        tbl[16] = v(1, 6, 32'h200, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[17] = v(1, 7, 32'h204, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[18] = v(1, 8, 32'h208, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        tbl[19] = v(1, 9, 32'h20C, 1, 0, 32'hA0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 32'hA0);
        tbl[20] = v(1, 10, 32'h210, 1, 1, 32'hB1, 0, 0, 1, 1,
                    0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
        tbl[21] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Fill to full, rejected allocs, commit against full, wrap, exception commit.
        for (int i = 0; i < 16; i++) begin
            hv[i] = v(1, 5'(i + 1), 32'h300 + 32'(4 * i), 0, 0, 0, 0, 0, 0, 4'(i),
                      0, 0, 0, 0, 0, 0, 0, (i == 0), 4'(i), 0, 0);
        end
        hv[16] = v(1, 5'h1F, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        hv[17] = v(1, 5'h1F, 32'hDEAD, 1, 0, 32'h55, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h55);
        hv[18] = v(1, 5'h1F, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0,
                   1, 0, 32'h55, 1, 32'h300, 0, 1, 0, 0, 1, 32'h55);
        hv[19] = v(1, 5'h11, 32'h400, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        hv[20] = v(0, 0, 0, 1, 1, 32'h66, 8'h01, 0, 0, 1,
                   0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h66);
        hv[21] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                   1, 1, 32'h66, 2, 32'h304, 8'h01, 1, 0, 1, 0, 0);
        hv[22] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        rst = 1'b0;
        flush = 1'b0;
        alloc_en = 1'b0;
        alloc_reg_write_en = 1'b0;
        alloc_reg_write_addr = '0;
        alloc_pc = '0;
        alloc_exception_type = '0;
        wb_en = 1'b0;
        wb_idx = '0;
        wb_data = '0;
        wb_exception_type = '0;
        commit_stall = 1'b0;
        read_idx_1 = '0;
        read_idx_2 = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset full", 32'(full), 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset alloc_idx", 32'(alloc_idx), 32'd0);
        chk("reset commit_en", 32'(commit_en), 32'd0);
        chk("reset read_done_1", 32'(read_done_1), 32'd0);
        chk("reset commit_data", commit_data, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            apply_vec($sformatf("tbl[%0d]", i), tbl[i]);
        end
        for (int i = 0; i < 23; i++) begin
            apply_vec($sformatf("hv[%0d]", i), hv[i]);
        end

        // Asynchronous reset in the middle of a cycle with 15 entries live.
        #2;
        rst = 1'b0;
        #1;
        chk("midrst full", 32'(full), 32'd0);
        chk("midrst empty", 32'(empty), 32'd1);
        chk("midrst alloc_idx", 32'(alloc_idx), 32'd0);
        chk("midrst commit_en", 32'(commit_en), 32'd0);
        chk("midrst commit_data", commit_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        apply_vec("post_rst alloc", v(1, 4, 32'h500, 0, 0, 0, 0, 0, 0, 0,
                                      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        apply_vec("post_rst idle", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
